axis_uart_tx_arbiter: RTL and testbench
=======================================

# axis_uart_tx_arbiter

Packet-level round-robin arbiter that lets NUM_SRC independent AXI-Stream byte sources share the single AXIS FIFO / UART transmit path. It sits between the per-source AXIS masters and the FIFO's slave port (s_axis_data/valid/ready/last). It grants one source at a time and holds the grant until that source's tlast beat is accepted, so packets are never interleaved on the serial line.

## Interface
Parameters:
- NUM_SRC, 4, number of requesting AXIS sources (2..16)
- WIDTH, 8, data width per beat

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_data  in  NUM_SRC*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH]
- s_axis_valid  in  NUM_SRC  per-source valid
- s_axis_last  in  NUM_SRC  per-source end-of-packet
- s_axis_ready  out  NUM_SRC  per-source ready; at most one bit high
- m_axis_data  out  WIDTH  data to FIFO/UART TX
- m_axis_valid  out  1  valid to FIFO
- m_axis_last  out  1  end-of-packet to FIFO
- m_axis_ready  in  1  ready from FIFO
- grant_id  out  $clog2(NUM_SRC)  index of the currently or most recently granted source
- busy  out  1  high while a grant is held (state != IDLE)

## Operation
- Registered state: state, grant (index), last_grant (index).
- States: IDLE, HDR (only with AXIS_ARB_HDR_EN), PASS.
- IDLE: all s_axis_ready = 0, m_axis_valid = 0. When any s_axis_valid is high, search indices last_grant+1, last_grant+2, ... modulo NUM_SRC; the first valid source wins. The grant register takes the winner; next state is HDR (macro defined) or PASS.
- HDR: m_axis_data = grant zero-extended to WIDTH, m_axis_valid = 1, m_axis_last = 0, all s_axis_ready = 0. On m_axis_ready go to PASS.
- PASS: combinational mux. m_axis_data/valid/last = source[grant] signals; s_axis_ready[grant] = m_axis_ready; other ready bits are 0.
- When s_axis_valid[grant] & s_axis_last[grant] & m_axis_ready: last_grant <= grant, and state goes to IDLE.
- Grant is held while the granted source drops valid mid-packet. There is no timeout. Other requesters wait.
- Non-granted sources never see ready. Their valid/data are ignored.
- Wrap-around: the search index wraps from NUM_SRC-1 to 0.
- A single-beat packet (valid & last on the first beat) is legal. It returns to IDLE after one PASS handshake.
- Reset mid-packet: state goes to IDLE immediately and the partial packet is truncated downstream. Recovery is the source's responsibility.

## Timing
- Reset values: state = IDLE, grant = 0, last_grant = NUM_SRC-1 (source 0 wins first), s_axis_ready = 0, m_axis_valid = 0, m_axis_last = 0, m_axis_data = 0, grant_id = 0, busy = 0.
- Arbitration costs exactly one cycle. A request seen in IDLE in cycle n gives PASS (or HDR) in cycle n+1, and the first beat can be accepted in n+1.
- Back-to-back packets have a one-cycle IDLE bubble between the tlast handshake and the next grant.
- In PASS, the data path is zero-latency combinational; ready follows m_axis_ready in the same cycle.
- Throughput in PASS is one beat per cycle when m_axis_ready is high.
- grant_id reflects the grant register; it updates the cycle after the arbitration decision.
- Simultaneous requests are resolved strictly by round-robin order, never by fixed priority.

## Configuration
- AXIS_ARB_HDR_EN defined: each packet is preceded by one header beat carrying the source index (HDR state). Requires WIDTH >= $clog2(NUM_SRC). Adds one beat per packet.
- AXIS_ARB_HDR_EN undefined: HDR state and logic are absent. IDLE goes directly to PASS, and the output stream is the byte-exact concatenation of source packets.

## Test plan
- Single source: src0 sends 3 beats 0x11,0x22,0x33 (last on 0x33). Required: the FIFO receives the same three bytes, m_axis_last on 0x33, busy high for 3 cycles, then IDLE.
- Contention: src0, src1 and src3 all valid from reset with 2-beat packets. Required: grant order 0,1,3, then src0 next. No interleaving, and exactly one IDLE cycle between packets.
- Backpressure: m_axis_ready toggles 1,0,0,1 during a 4-beat packet from src2. Required: s_axis_ready[2] mirrors it, data is held stable, and no beats are lost or duplicated.
- Stall mid-packet: src1 drops valid for 5 cycles after beat 1 while src0 is requesting. Required: grant stays on 1 and src0 gets no ready until src1's tlast is accepted.
- Reset mid-packet: assert rst for 1 cycle during beat 2 of src3. Required: the next cycle shows all outputs at their reset values, and the next grant goes to the lowest-index valid source.
- With AXIS_ARB_HDR_EN: src2 sends 0xA5 (single beat). Required: the FIFO receives 0x02 (last = 0), then 0xA5 (last = 1).

Source files
------------

// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter
// Packet-level round-robin arbiter that merges NUM_SRC AXI-Stream byte sources
// onto the single UART TX FIFO slave port. A grant is held until the granted
// source's tlast beat is accepted, so packets never interleave on the line.
// Optional feature macro: AXIS_ARB_HDR_EN -- when defined, each packet is
// preceded by one header beat carrying the granted source index.
module axis_uart_tx_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*WIDTH-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]         s_axis_valid,
    input  logic [NUM_SRC-1:0]         s_axis_last,
    output logic [NUM_SRC-1:0]         s_axis_ready,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_SRC);

`ifdef AXIS_ARB_HDR_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PASS} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PASS} state_t;
`endif

    state_t                         state, state_nxt;
    logic [IW-1:0]                  grant, grant_nxt;
    logic [IW-1:0]                  last_grant, last_grant_nxt;
    logic [IW-1:0]                  winner, win_hi, win_lo;
    logic                           found_hi;
    logic [NUM_SRC-1:0][WIDTH-1:0]  src_data;

    // Per-source view of the flat data bus so the mux indexes by grant directly
    assign src_data = s_axis_data;

    // Round-robin pick: lowest valid index above last_grant, else lowest valid overall
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (s_axis_valid[i]) begin
                if (i > int'(last_grant)) begin
                    win_hi   = IW'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo = IW'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= IW'(NUM_SRC - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic and the zero-latency output mux
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        s_axis_ready   = '0;
        m_axis_data    = '0;
        m_axis_valid   = 1'b0;
        m_axis_last    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|s_axis_valid) begin
                    grant_nxt = winner;
`ifdef AXIS_ARB_HDR_EN
                    state_nxt = S_HDR;
`else
                    state_nxt = S_PASS;
`endif
                end
            end
`ifdef AXIS_ARB_HDR_EN
            S_HDR: begin
                m_axis_data  = WIDTH'(grant);
                m_axis_valid = 1'b1;
                if (m_axis_ready) begin
                    state_nxt = S_PASS;
                end
            end
`endif
            S_PASS: begin
                m_axis_data         = src_data[grant];
                m_axis_valid        = s_axis_valid[grant];
                m_axis_last         = s_axis_last[grant];
                s_axis_ready[grant] = m_axis_ready;
                // Grant is released only on the accepted tlast beat
                if (s_axis_valid[grant] && s_axis_last[grant] && m_axis_ready) begin
                    last_grant_nxt = grant;
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign grant_id = grant;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: directed packets per source, a transaction
// level arbiter model checked against the DUT every cycle, plus literal
// expectations on received byte streams and grant order.
module tb_axis_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int P_IDLE = 0, P_HDR = 1, P_PASS = 2;
`ifdef AXIS_ARB_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] s_axis_data;
    logic [N-1:0]   s_axis_valid, s_axis_last, s_axis_ready;
    logic [W-1:0]   m_axis_data;
    logic           m_axis_valid, m_axis_last, m_axis_ready;
    logic [IW-1:0]  grant_id;
    logic           busy;

    always #5 clk = ~clk;

    axis_uart_tx_arbiter #(.NUM_SRC(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .grant_id(grant_id), .busy(busy)
    );

    // source beat tables
    logic [7:0]   tab_d [N][16];
    logic         tab_l [N][16];
    int           src_len [N];
    int           src_ptr [N];
    logic [N-1:0] hold;
    logic [N-1:0] hs = '0;
    logic         mr_next;

    int n_assert = 0;
    int n_fail   = 0;

    // model state: phase of the shared link, current owner, previous owner
    int         mdl_phase = P_IDLE;
    int         mdl_owner = 0;
    int         mdl_prev  = N - 1;
    bit         found;
    logic       chk_en = 1'b0;
    logic [W-1:0]  e_data;
    logic          e_valid, e_last;
    logic [N-1:0]  e_rdy;
    int         busy_cnt = 0;
    int         rdy_cnt [N];
    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];
    int         glog[$];
    int         exp_g[$];

    initial for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

    // compare DUT to the model each cycle, then advance the model
    always @(negedge clk) begin
        e_data  = '0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_rdy   = '0;
        if (mdl_phase == P_HDR) begin
            e_data  = W'(mdl_owner);
            e_valid = 1'b1;
        end else if (mdl_phase == P_PASS) begin
            e_data           = s_axis_data[mdl_owner*W +: W];
            e_valid          = s_axis_valid[mdl_owner];
            e_last           = s_axis_last[mdl_owner];
            e_rdy[mdl_owner] = m_axis_ready;
        end
        if (chk_en) begin
            n_assert++;
            if (m_axis_data !== e_data || m_axis_valid !== e_valid || m_axis_last !== e_last ||
                s_axis_ready !== e_rdy || grant_id !== IW'(mdl_owner) ||
                busy !== (mdl_phase != P_IDLE)) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: got data=%h v=%b l=%b rdy=%b gid=%0d busy=%b, need data=%h v=%b l=%b rdy=%b gid=%0d busy=%b",
                         $time, m_axis_data, m_axis_valid, m_axis_last, s_axis_ready, grant_id, busy,
                         e_data, e_valid, e_last, e_rdy, mdl_owner, (mdl_phase != P_IDLE));
            end
            if (busy) busy_cnt++;
            for (int i = 0; i < N; i++) if (s_axis_ready[i]) rdy_cnt[i]++;
            if (m_axis_valid && m_axis_ready) rx_q.push_back({m_axis_last, m_axis_data});
        end
        hs = s_axis_valid & s_axis_ready;
        if (rst) begin
            mdl_phase = P_IDLE;
            mdl_owner = 0;
            mdl_prev  = N - 1;
        end else if (mdl_phase == P_IDLE) begin
            if (s_axis_valid != '0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && s_axis_valid[(mdl_prev + k) % N]) begin
                        found     = 1'b1;
                        mdl_owner = (mdl_prev + k) % N;
                    end
                end
                glog.push_back(mdl_owner);
                mdl_phase = HDR_EN ? P_HDR : P_PASS;
            end
        end else if (mdl_phase == P_HDR) begin
            if (m_axis_ready) mdl_phase = P_PASS;
        end else begin
            if (s_axis_valid[mdl_owner] && s_axis_last[mdl_owner] && m_axis_ready) begin
                mdl_prev  = mdl_owner;
                mdl_phase = P_IDLE;
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            if (src_ptr[i] < src_len[i]) begin
                s_axis_data[i*W +: W] = tab_d[i][src_ptr[i]];
                s_axis_last[i]        = tab_l[i][src_ptr[i]];
                s_axis_valid[i]       = !hold[i];
            end else begin
                s_axis_data[i*W +: W] = '0;
                s_axis_last[i]        = 1'b0;
                s_axis_valid[i]       = 1'b0;
            end
        end
        m_axis_ready = mr_next;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) src_ptr[i]++;
        apply();
    endtask

    task automatic add_pkt(int s, int n, logic [63:0] b);
        for (int j = 0; j < n; j++) begin
            tab_d[s][src_len[s]] = b[(n-1-j)*8 +: 8];
            tab_l[s][src_len[s]] = (j == n - 1);
            src_len[s]++;
        end
    endtask

    task automatic exp_pkt(int s, int n, logic [63:0] b);
        if (HDR_EN) exp_q.push_back({1'b0, W'(s)});
        for (int j = 0; j < n; j++) exp_q.push_back({(j == n - 1), b[(n-1-j)*8 +: 8]});
    endtask

    task automatic clr_all();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        hold = '0;
        exp_q.delete();
        exp_g.delete();
    endtask

    function automatic bit all_done();
        bit d = (mdl_phase == P_IDLE);
        for (int i = 0; i < N; i++) if (src_ptr[i] < src_len[i]) d = 1'b0;
        return d;
    endfunction

    task automatic run(string name, int max, output int steps);
        steps = 0;
        while (!all_done()) begin
            if (steps >= max) begin
                n_assert++;
                n_fail++;
                $display("FAIL %s_timeout: still busy after %0d cycles, required done within %0d", name, steps, max);
                return;
            end
            step();
            steps++;
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_rx(string name, int base);
        int bad = -1;
        n_assert++;
        if (rx_q.size() - base != exp_q.size()) bad = exp_q.size();
        else foreach (exp_q[i]) if (bad < 0 && rx_q[base + i] !== exp_q[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: got %0d beats, required %0d; first difference at beat %0d (got %h, required %h)",
                     name, rx_q.size() - base, exp_q.size(), bad,
                     (bad < rx_q.size() - base) ? rx_q[base + bad] : 9'h0,
                     (bad < exp_q.size()) ? exp_q[bad] : 9'h0);
        end
    endtask

    task automatic check_glog(string name, int base);
        int bad = -1;
        n_assert++;
        if (glog.size() - base != exp_g.size()) bad = exp_g.size();
        else foreach (exp_g[i]) if (bad < 0 && glog[base + i] != exp_g[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: got %0d grants, required %0d; first difference at grant %0d",
                     name, glog.size() - base, exp_g.size(), bad);
        end
    endtask

    int rxb, gb, bb, rb0, rb2, steps;
    logic [1:0] bp [8] = '{1, 1, 0, 0, 1, 1, 1, 1};

    initial begin
        rst          = 1'b1;
        s_axis_data  = '0;
        s_axis_valid = '0;
        s_axis_last  = '0;
        m_axis_ready = 1'b0;
        mr_next      = 1'b1;
        clr_all();

        // reset values
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", m_axis_valid, 0);
        check("rst_last",  m_axis_last, 0);
        check("rst_data",  m_axis_data, 0);
        check("rst_ready", s_axis_ready, 0);
        check("rst_gid",   grant_id, 0);
        check("rst_busy",  busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single source, 3 beats
        clr_all();
        rxb = rx_q.size(); bb = busy_cnt;
        add_pkt(0, 3, 64'h112233);
        exp_pkt(0, 3, 64'h112233);
        run("t1", 30, steps);
        check_rx("t1_stream", rxb);
        check("t1_busy_cycles", busy_cnt - bb, 3 + HDR_EN);

        // contention from reset: 0,1,3 then 0 again, one bubble between packets
        clr_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rxb = rx_q.size(); gb = glog.size(); bb = busy_cnt;
        add_pkt(0, 2, 64'hA0A1); add_pkt(0, 2, 64'hA2A3);
        add_pkt(1, 2, 64'hB0B1); add_pkt(3, 2, 64'hD0D1);
        exp_pkt(0, 2, 64'hA0A1); exp_pkt(1, 2, 64'hB0B1);
        exp_pkt(3, 2, 64'hD0D1); exp_pkt(0, 2, 64'hA2A3);
        exp_g = '{0, 1, 3, 0};
        run("t2", 60, steps);
        check_rx("t2_stream", rxb);
        check_glog("t2_grant_order", gb);
        check("t2_busy_cycles", busy_cnt - bb, 8 + 4 * HDR_EN);
        check("t2_total_cycles", steps, 13 + 4 * HDR_EN);

        // backpressure on a 4-beat packet from src2
        clr_all();
        rxb = rx_q.size(); bb = busy_cnt; rb2 = rdy_cnt[2];
        add_pkt(2, 4, 64'hC0C1C2C3);
        exp_pkt(2, 4, 64'hC0C1C2C3);
        for (int k = 0; k < 8; k++) begin
            mr_next = bp[k][0];
            step();
        end
        mr_next = 1'b1;
        run("t3", 30, steps);
        check_rx("t3_stream", rxb);
        check("t3_busy_cycles", busy_cnt - bb, 6 + HDR_EN);
        check("t3_ready2_cycles", rdy_cnt[2] - rb2, 4);

        // src1 stalls 5 cycles after beat 1 while src0 waits
        clr_all();
        rxb = rx_q.size(); gb = glog.size(); rb0 = rdy_cnt[0];
        add_pkt(1, 3, 64'hE0E1E2);
        step();
        step();
        if (HDR_EN) step();
        hold[1] = 1'b1;
        add_pkt(0, 1, 64'hF0);
        repeat (3) step();
        @(negedge clk);
        check("t4_hold_gid", grant_id, 1);
        check("t4_hold_rdy0", s_axis_ready[0], 0);
        repeat (2) step();
        hold[1] = 1'b0;
        exp_pkt(1, 3, 64'hE0E1E2); exp_pkt(0, 1, 64'hF0);
        exp_g = '{1, 0};
        run("t4", 40, steps);
        check_rx("t4_stream", rxb);
        check_glog("t4_grant_order", gb);
        check("t4_ready0_cycles", rdy_cnt[0] - rb0, 1);

        // reset during beat 2 of src3; next grant to lowest valid source
        clr_all();
        add_pkt(3, 4, 64'h30313233);
        step();
        step();
        if (HDR_EN) step();
        step();
        rst = 1'b1;
        add_pkt(1, 2, 64'h4041); add_pkt(2, 1, 64'h50);
        src_len[3] = 0;
        src_ptr[3] = 0;
        step();
        rst = 1'b0;
        rxb = rx_q.size(); gb = glog.size();
        @(negedge clk);
        check("t5_valid", m_axis_valid, 0);
        check("t5_last",  m_axis_last, 0);
        check("t5_data",  m_axis_data, 0);
        check("t5_ready", s_axis_ready, 0);
        check("t5_gid",   grant_id, 0);
        check("t5_busy",  busy, 0);
        exp_pkt(1, 2, 64'h4041); exp_pkt(2, 1, 64'h50);
        exp_g = '{1, 2};
        run("t5", 40, steps);
        check_rx("t5_stream", rxb);
        check_glog("t5_grant_order", gb);

        // single-beat packet from src2 (header beat 0x02 first when enabled)
        clr_all();
        rxb = rx_q.size();
        add_pkt(2, 1, 64'hA5);
        exp_pkt(2, 1, 64'hA5);
        run("t6", 20, steps);
        check_rx("t6_stream", rxb);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
